// File: rtl/program_counter.sv
// program_counter: fetch-stage instruction-address register.
// On every rising clock edge it either advances by STEP bytes or loads a
// branch/jump target. An asynchronous active-low reset returns the register
// to RESET_VECTOR. The output comes straight from the register, so no input
// has a combinational path to instr_addr.
module program_counter #(
   parameter int                XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
   parameter int                STEP         = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            imm,
   input  logic [XLEN-1:0] imm_addr,
   output logic [XLEN-1:0] instr_addr
);

   localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

   // Sequential advance. The sum is modulo 2^XLEN, so the top word wraps
   // to zero with no flag or saturation.
   function automatic logic [XLEN-1:0] wrap_add(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [XLEN:0] sum;
      sum      = {1'b0, a} + {1'b0, b};
      wrap_add = sum[XLEN-1:0];
   endfunction

   logic [XLEN-1:0] pc_p0;
   logic [XLEN-1:0] pc_next;

   // Next address: the target is taken verbatim (no alignment masking),
   // otherwise advance by one instruction word.
   always_comb begin
      pc_next = wrap_add(pc_p0, STEP_W);
      if (imm) begin
         pc_next = imm_addr;
      end
   end

   // Address register; reset has priority over any clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_p0 <= RESET_VECTOR;
      end else begin
         pc_p0 <= pc_next;
      end
   end

   assign instr_addr = pc_p0;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed and randomized stimulus for program_counter,
// checked against a simple behavioural model of the instruction address.
module tb_program_counter;

   logic        clk;
   logic        rst;
   logic        imm;
   logic [31:0] imm_addr;
   logic [31:0] instr_addr;

   int          n_checks;
   int          n_errors;
   logic [31:0] model_pc;

   program_counter #(
      .XLEN(32),
      .RESET_VECTOR(32'h0000_0000),
      .STEP(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .imm(imm),
      .imm_addr(imm_addr),
      .instr_addr(instr_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given controls; the model then applies the
   // architectural rule and the output is sampled 1 time unit later.
   task automatic cycle(input string tag, input logic i, input logic [31:0] a);
      imm      = i;
      imm_addr = a;
      @(posedge clk);
      if (!rst)      model_pc = 32'h0;
      else if (i)    model_pc = a;
      else           model_pc = model_pc + 32'd4;
      #1;
      check(tag, instr_addr, model_pc);
   endtask

   // Reset pulse placed strictly between clock edges.
   task automatic async_reset_pulse(input string tag);
      #2;
      rst = 1'b0;
      #1;
      model_pc = 32'h0;
      check(tag, instr_addr, model_pc);
      rst = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_pc = 32'h0;
      rst      = 1'b0;
      imm      = 1'b1;
      imm_addr = 32'hDEAD_BEEF;

      #2;
      check("reset_level", instr_addr, 32'h0);
      cycle("reset_hold_edge", 1'b1, 32'hDEAD_BEEF);
      check("reset_hold_const", instr_addr, 32'h0000_0000);

      rst = 1'b1;
      cycle("seq_4", 1'b0, 32'h0);
      check("seq_4_const", instr_addr, 32'h0000_0004);
      cycle("seq_8", 1'b0, 32'h0);
      cycle("seq_c", 1'b0, 32'h0);
      check("seq_c_const", instr_addr, 32'h0000_000C);

      cycle("load_1000", 1'b1, 32'h0000_1000);
      check("load_1000_const", instr_addr, 32'h0000_1000);
      cycle("after_load", 1'b0, 32'h0);
      check("after_load_const", instr_addr, 32'h0000_1004);

      // Reset held low across an edge with a pending load: reset wins.
      rst = 1'b0;
      #1;
      model_pc = 32'h0;
      check("async_clear", instr_addr, model_pc);
      cycle("reset_over_load", 1'b1, 32'h0000_0500);
      check("reset_over_load_const", instr_addr, 32'h0);
      rst = 1'b1;
      cycle("release_inc", 1'b0, 32'h0);
      check("release_inc_const", instr_addr, 32'h0000_0004);

      cycle("wrap_load", 1'b1, 32'hFFFF_FFFC);
      cycle("wrap_zero", 1'b0, 32'h0);
      check("wrap_zero_const", instr_addr, 32'h0000_0000);
      cycle("wrap_four", 1'b0, 32'h0);
      check("wrap_four_const", instr_addr, 32'h0000_0004);

      cycle("b2b_20", 1'b1, 32'h0000_0020);
      cycle("b2b_80", 1'b1, 32'h0000_0080);
      cycle("b2b_03", 1'b1, 32'h0000_0003);
      check("unaligned_const", instr_addr, 32'h0000_0003);
      cycle("unaligned_inc", 1'b0, 32'h0);
      check("unaligned_inc_const", instr_addr, 32'h0000_0007);

      async_reset_pulse("pulse_clear");
      cycle("after_pulse", 1'b0, 32'h0);
      check("after_pulse_const", instr_addr, 32'h0000_0004);

      for (int k = 0; k < 400; k++) begin
         int unsigned sel;
         logic [31:0] a;
         sel = $urandom_range(0, 15);
         a   = $urandom;
         if (sel == 0) begin
            async_reset_pulse("rand_pulse");
         end else if (sel == 1) begin
            cycle("rand_near_wrap", 1'b1, 32'hFFFF_FFF0 | (a & 32'hC));
         end else begin
            cycle("rand_step", (sel < 7), a);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
